// File: rtl/prog_priority_arbiter_seq_pkg.sv
// Shared types and helpers for the registered programmable-priority arbiter.
// Holds the width helper, reset priority constant and FSM state encoding.
package prog_priority_arbiter_seq_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  // Index width; never below 1 so single-bit buses stay legal.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

  function automatic int reset_prio(input int idx, input int pw);
    return idx % (1 << pw);
  endfunction

endpackage

// File: rtl/prog_priority_arbiter_seq_if.sv
// Request / configuration / grant bundle between bus masters and the arbiter.
interface prog_priority_arbiter_seq_if #(
  parameter int N  = 4,
  parameter int PW = prog_priority_arbiter_seq_pkg::clog2(N)
);
  localparam int IW = prog_priority_arbiter_seq_pkg::clog2(N);

  logic [N-1:0]  req;
  logic          cfg_we;
  logic [IW-1:0] cfg_idx;
  logic [PW-1:0] cfg_prio;
  logic [N-1:0]  grant;
  logic          grant_valid;
  logic [IW-1:0] grant_idx;

  modport master (
    output req, cfg_we, cfg_idx, cfg_prio,
    input  grant, grant_valid, grant_idx
  );

  modport slave (
    input  req, cfg_we, cfg_idx, cfg_prio,
    output grant, grant_valid, grant_idx
  );
endinterface

// File: rtl/prog_priority_arbiter_seq_prio_select.sv
// Combinational N-way picker: aged first, then lowest priority value,
// then lowest index, among eligible channels only.
module prog_priority_arbiter_seq_prio_select
  import prog_priority_arbiter_seq_pkg::*;
#(
  parameter int N  = 4,
  parameter int PW = 2,
  localparam int IW = clog2(N)
) (
  input  logic [N-1:0]    elig,
  input  logic [N-1:0]    aged,
  input  logic [N*PW-1:0] prio_flat,
  output logic [N-1:0]    win,
  output logic [IW-1:0]   win_idx
);

  logic          found;
  logic [PW:0]   key;
  logic [PW:0]   best_key;

  // Aged channels get a leading 0 in the key so they sort ahead of all others.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    found    = 1'b0;
    key      = '0;
    best_key = '0;
    win_idx  = '0;
    for (int i = 0; i < N; i++) begin
      key = {~aged[i], prio_flat[i*PW +: PW]};
      if (elig[i] && (!found || key < best_key)) begin
        found    = 1'b1;
        best_key = key;
        win_idx  = IW'(i);
      end
    end
    win = found ? (N'(1) << win_idx) : '0;
  end

endmodule

// File: rtl/prog_priority_arbiter_seq.sv
// Registered programmable fixed-priority arbiter with grant lock,
// burst-hold limit and per-channel aging.
module prog_priority_arbiter_seq
  import prog_priority_arbiter_seq_pkg::*;
#(
  parameter int N        = 4,
  parameter int PW       = clog2(N),
  parameter int HOLD_MAX = 8,
  parameter int AGE_MAX  = 16
) (
  input logic                       clk,
  input logic                       rst,
  prog_priority_arbiter_seq_if.slave bus
);

  localparam int IW = clog2(N);
  localparam int HW = clog2(HOLD_MAX + 1);
  localparam int AW = clog2(AGE_MAX + 1);

  state_t                  state_q, state_d;
  logic [N-1:0]            grant_q, grant_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [HW-1:0]           hold_q, hold_d;
  logic [N-1:0][PW-1:0]    prio_q;
  logic [N-1:0][AW-1:0]    age_q;

  logic [N-1:0]  elig, aged, win;
  logic [IW-1:0] win_idx;
  logic          holder_req, others_req, hold_hit, excl_holder;

  assign holder_req  = |(bus.req & grant_q);
  assign others_req  = |(bus.req & ~grant_q);
  assign hold_hit    = (HOLD_MAX != 0) && (hold_q == HW'(HOLD_MAX));
  assign excl_holder = (state_q == GRANT) && holder_req && hold_hit && others_req;
  // A released holder drops out through its own req; a hold-limited one is masked here.
  assign elig        = bus.req & ~(excl_holder ? grant_q : '0);

  always_comb begin
    aged = '0;
    for (int i = 0; i < N; i++)
      aged[i] = (AGE_MAX != 0) && (age_q[i] == AW'(AGE_MAX));
  end

  prog_priority_arbiter_seq_prio_select #(.N(N), .PW(PW)) u_select (
    .elig      (elig),
    .aged      (aged),
    .prio_flat (prio_q),
    .win       (win),
    .win_idx   (win_idx)
  );

  always_comb begin
    logic arb;
    arb     = 1'b0;
    state_d = state_q;
    grant_d = grant_q;
    idx_d   = idx_q;
    hold_d  = hold_q;
    case (state_q)
      IDLE:  arb = 1'b1;
      GRANT: begin
        if (!holder_req || excl_holder) arb = 1'b1;
        else if (hold_hit)              hold_d = HW'(1);
        else if ((HOLD_MAX != 0) && (hold_q < HW'(HOLD_MAX)))
          hold_d = hold_q + HW'(1);
      end
      default: arb = 1'b1;
    endcase
    if (arb) begin
      if (|win) begin
        state_d = GRANT;
        grant_d = win;
        idx_d   = win_idx;
        hold_d  = HW'(1);
      end else begin
        state_d = IDLE;
        grant_d = '0;
        idx_d   = '0;
        hold_d  = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the priority table is reset too -- its default contents are functional, not don't-care.
      state_q <= IDLE;
      grant_q <= '0;
      idx_q   <= '0;
      hold_q  <= '0;
      age_q   <= '0;
      for (int i = 0; i < N; i++) prio_q[i] <= PW'(reset_prio(i, PW));
    end else begin
      // NOTE: non-blocking updates so every register sees the pre-edge values of the others.
      state_q <= state_d;
      grant_q <= grant_d;
      idx_q   <= idx_d;
      hold_q  <= hold_d;
      if (bus.cfg_we && (int'(bus.cfg_idx) < N)) prio_q[bus.cfg_idx] <= bus.cfg_prio;
      for (int i = 0; i < N; i++) begin
        if (bus.req[i] && !grant_q[i]) begin
          if ((AGE_MAX != 0) && (age_q[i] < AW'(AGE_MAX))) age_q[i] <= age_q[i] + AW'(1);
        end else begin
          age_q[i] <= '0;
        end
      end
    end
  end

  assign bus.grant       = grant_q;
  assign bus.grant_valid = |grant_q;
  assign bus.grant_idx   = idx_q;

endmodule

// File: tb/tb_prog_priority_arbiter_seq.sv
// Self-checking bench: table-driven vectors plus hand sequences for hold limit,
// aging and mid-grant reset, with expected grants queued per driven cycle.
module tb_prog_priority_arbiter_seq;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  prog_priority_arbiter_seq_if #(.N(4), .PW(2)) ifa ();
  prog_priority_arbiter_seq_if #(.N(4), .PW(2)) ifb ();

  prog_priority_arbiter_seq #(.N(4), .PW(2), .HOLD_MAX(4), .AGE_MAX(16)) dut_a (
    .clk (clk), .rst (rst), .bus (ifa)
  );
  prog_priority_arbiter_seq #(.N(4), .PW(2), .HOLD_MAX(0), .AGE_MAX(8)) dut_b (
    .clk (clk), .rst (rst), .bus (ifb)
  );

  typedef struct {
    logic [3:0] req;
    logic       we;
    logic [1:0] idx;
    logic [1:0] prio;
    logic [3:0] exp;
  } vec_t;

  vec_t       vecs[$];
  logic [3:0] sb_q[$];
  int         checks = 0;
  int         errors = 0;
  int         step_n = 0;

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  function automatic logic [3:0] idx_of(input logic [3:0] oh);
    logic [3:0] r;
    r = 4'd0;
    for (int i = 0; i < 4; i++) if (oh[i]) r = 4'(i);
    return r;
  endfunction

  // One clock: drive at negedge, queue expectation, compare #1 after posedge.
  task automatic cycle(input bit sel, input string tag, input logic [3:0] r,
                       input logic we, input logic [1:0] idx, input logic [1:0] pr,
                       input logic [3:0] exp);
    logic [3:0] e, g, gi;
    logic       gv;
    if (!sel) begin
      ifa.req = r; ifa.cfg_we = we; ifa.cfg_idx = idx; ifa.cfg_prio = pr;
    end else begin
      ifb.req = r; ifb.cfg_we = we; ifb.cfg_idx = idx; ifb.cfg_prio = pr;
    end
    sb_q.push_back(exp);
    @(posedge clk);
    #1;
    e  = sb_q.pop_front();
    g  = sel ? ifb.grant : ifa.grant;
    gi = 4'(sel ? ifb.grant_idx : ifa.grant_idx);
    gv = sel ? ifb.grant_valid : ifa.grant_valid;
    check($sformatf("%s#%0d grant", tag, step_n), g, e);
    check($sformatf("%s#%0d grant_idx", tag, step_n), gi, idx_of(e));
    check($sformatf("%s#%0d grant_valid", tag, step_n), {3'b0, gv}, {3'b0, |e});
    step_n++;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    ifa.req = '0; ifa.cfg_we = 1'b0; ifa.cfg_idx = '0; ifa.cfg_prio = '0;
    ifb.req = '0; ifb.cfg_we = 1'b0; ifb.cfg_idx = '0; ifb.cfg_prio = '0;
    @(negedge clk);
    cycle(0, "reset_a", 4'b0000, 0, 0, 0, 4'b0000);
    cycle(1, "reset_b", 4'b0000, 0, 0, 0, 4'b0000);
    rst = 1'b0;

    // Defaults, programming, tie-break, lock/hand-off, same-cycle cfg, no revoke.
    vecs.push_back('{4'b1010, 1'b0, 2'd0, 2'd0, 4'b0010});
    vecs.push_back('{4'b0000, 1'b0, 2'd0, 2'd0, 4'b0000});
    vecs.push_back('{4'b0000, 1'b1, 2'd3, 2'd0, 4'b0000});
    vecs.push_back('{4'b0000, 1'b1, 2'd1, 2'd3, 4'b0000});
    vecs.push_back('{4'b1010, 1'b0, 2'd0, 2'd0, 4'b1000});
    vecs.push_back('{4'b0000, 1'b0, 2'd0, 2'd0, 4'b0000});
    vecs.push_back('{4'b0000, 1'b1, 2'd0, 2'd1, 4'b0000});
    vecs.push_back('{4'b0000, 1'b1, 2'd2, 2'd1, 4'b0000});
    vecs.push_back('{4'b0101, 1'b0, 2'd0, 2'd0, 4'b0001});
    vecs.push_back('{4'b0000, 1'b0, 2'd0, 2'd0, 4'b0000});
    vecs.push_back('{4'b0010, 1'b0, 2'd0, 2'd0, 4'b0010});
    vecs.push_back('{4'b0011, 1'b0, 2'd0, 2'd0, 4'b0010});
    vecs.push_back('{4'b0001, 1'b0, 2'd0, 2'd0, 4'b0001});
    vecs.push_back('{4'b0000, 1'b0, 2'd0, 2'd0, 4'b0000});
    vecs.push_back('{4'b1100, 1'b1, 2'd3, 2'd3, 4'b1000});
    vecs.push_back('{4'b0000, 1'b0, 2'd0, 2'd0, 4'b0000});
    vecs.push_back('{4'b1100, 1'b0, 2'd0, 2'd0, 4'b0100});
    vecs.push_back('{4'b0000, 1'b0, 2'd0, 2'd0, 4'b0000});
    vecs.push_back('{4'b0100, 1'b0, 2'd0, 2'd0, 4'b0100});
    vecs.push_back('{4'b0101, 1'b1, 2'd2, 2'd0, 4'b0100});
    vecs.push_back('{4'b0101, 1'b0, 2'd0, 2'd0, 4'b0100});
    vecs.push_back('{4'b0001, 1'b0, 2'd0, 2'd0, 4'b0001});
    vecs.push_back('{4'b0000, 1'b0, 2'd0, 2'd0, 4'b0000});
    foreach (vecs[i])
      cycle(0, "vec", vecs[i].req, vecs[i].we, vecs[i].idx, vecs[i].prio, vecs[i].exp);

    // Hold limit 4 with table p0=1 p2=0: ch2, ch0, ch2 in 4-cycle turns.
    for (int i = 0; i < 12; i++)
      cycle(0, "hold", 4'b0101, 0, 0, 0, ((i / 4) % 2 == 0) ? 4'b0100 : 4'b0001);
    cycle(0, "hold_rel", 4'b0000, 0, 0, 0, 4'b0000);
    for (int i = 0; i < 10; i++)
      cycle(0, "hold_solo", 4'b0001, 0, 0, 0, 4'b0001);
    cycle(0, "hold_rel", 4'b0000, 0, 0, 0, 4'b0000);

    // Reset mid-grant drops the grant and restores the identity table.
    cycle(0, "rst_pre", 4'b0100, 0, 0, 0, 4'b0100);
    rst = 1'b1;
    cycle(0, "rst_mid", 4'b0100, 0, 0, 0, 4'b0000);
    rst = 1'b0;
    cycle(0, "rst_post", 4'b0100, 0, 0, 0, 4'b0100);
    cycle(0, "rst_post", 4'b0000, 0, 0, 0, 4'b0000);
    cycle(0, "rst_table", 4'b0110, 0, 0, 0, 4'b0010);
    cycle(0, "rst_table", 4'b0000, 0, 0, 0, 4'b0000);

    // Aging on dut_b: ch3 waits behind overlapping ch0/ch1 bursts until age 8.
    begin
      logic [3:0] ag_req[11];
      logic [3:0] ag_exp[11];
      ag_req = '{4'b1001, 4'b1001, 4'b1011, 4'b1010, 4'b1011, 4'b1001,
                 4'b1011, 4'b1010, 4'b1011, 4'b1001, 4'b1001};
      ag_exp = '{4'b0001, 4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0001,
                 4'b0001, 4'b0010, 4'b0010, 4'b1000, 4'b1000};
      for (int i = 0; i < 11; i++)
        cycle(1, "aging", ag_req[i], 0, 0, 0, ag_exp[i]);
      cycle(1, "aging_rel", 4'b0000, 0, 0, 0, 4'b0000);
    end

    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard: %0d expectations left unchecked", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/prog_priority_arbiter_seq.md
# prog_priority_arbiter_seq

Registered, parametrised successor to the 4-channel combinational programmable fixed-priority arbiter. It takes N requesters and a runtime-writable priority table. Grants are one-hot and registered, and stay locked to the winner until it releases. A burst-hold limit and per-channel aging counters bound the wait of low-priority channels. The block sits between N bus masters and a single shared resource port.

## Interface
- N, default 4: number of request channels (≥2).
- PW, default $clog2(N): bits per priority level; 0 is the highest priority.
- HOLD_MAX, default 8: maximum consecutive grant cycles while others wait; 0 disables the limit.
- AGE_MAX, default 16: number of waiting cycles after which a channel is promoted; 0 disables aging.
- clk  in  1  single clock; all state changes on the rising edge.
- rst  in  1  synchronous reset, active-high.
- req  in  N  request vector, level-sensitive.
- cfg_we  in  1  priority table write strobe.
- cfg_idx  in  $clog2(N)  channel whose priority is written.
- cfg_prio  in  PW  new priority level for that channel.
- grant  out  N  one-hot grant, registered.
- grant_valid  out  1  equals |grant.
- grant_idx  out  $clog2(N)  binary index of the granted channel; 0 when no grant.

## Operation
- Priority table: prio[i] is PW bits wide.
  - Reset value is prio[i] = i mod 2^PW.
  - On cfg_we, prio[cfg_idx] <= cfg_prio. A cfg_idx ≥ N is ignored.
  - Duplicate levels are legal.
- Selection order:
  - Aged channels (age==AGE_MAX) outrank all others.
  - Otherwise the lowest prio value wins.
  - Ties go to the lowest index.
  - Only channels with req high are eligible.
- Arbitration takes place in a cycle when any of these holds:
  - no grant is held;
  - the holder's req is low;
  - hold_cnt==HOLD_MAX (HOLD_MAX≠0) and at least one other channel requests.
- On a hold-limit re-arbitration the holder is excluded. If it is the only requester, it keeps the grant and hold_cnt reloads to 1.
- Lock: in all other cycles the grant is unchanged, regardless of new higher-priority requests.
- Counters:
  - hold_cnt loads 1 on a new grant, increments while held, and saturates at HOLD_MAX.
  - age[i] increments, saturating at AGE_MAX, each cycle req[i]=1 and grant[i]=0.
  - age[i] clears when the channel is granted or req[i]=0.
- State machine:
  - IDLE (no grant) -> GRANT on any req.
  - GRANT -> GRANT with a new or the same winner on re-arbitration with eligible requesters.
  - GRANT -> IDLE when the holder releases and no other req is present.

## Timing
- Reset values: grant=0, grant_valid=0, grant_idx=0, hold_cnt=0, all age=0, table at defaults. Reset mid-grant drops the grant on the next edge.
- Latency:
  - req sampled at edge k gives grant at edge k+1.
  - Release is bubble-free: the holder's req low in cycle k hands the grant to the next winner at edge k+1.
  - The grant follows req with one cycle of latency, so the holder keeps grant for exactly one cycle after its req drops.
- cfg write at edge k: the new priority is used for arbitrations from cycle k+1 onward. It never revokes a held grant.
- cfg_we together with an arbitration in the same cycle: arbitration uses the old table value.
- grant is always one-hot or zero. grant_idx and grant_valid are consistent with grant in the same cycle.

## Structure
- Shared package: width function clog2, the reset-priority constant function, and the state enum {IDLE, GRANT}.
- One sub-module, prio_select:
  - combinational N-way picker;
  - inputs: eligible mask, aged mask, flattened prio bus;
  - outputs: one-hot winner and index.
- The top level holds the table, counters, FSM and output registers.

## Test plan
- Reset defaults: after rst, req=4'b1010 -> grant=4'b0010, grant_idx=1 one cycle later.
- Programming: write prio[3]=0 and prio[1]=3, then req=4'b1010 -> grant=4'b1000. Write prio[0]=prio[2]=1, then req=4'b0101 -> grant=4'b0001 (tie goes to the lowest index).
- Lock and hand-off: ch1 granted, ch0 raises req -> grant stays 4'b0010. Drop req[1] at cycle k -> grant=4'b0001 at k+1, with no idle cycle.
- Hold limit, HOLD_MAX=4: req=4'b0101 held continuously -> ch0 granted 4 cycles, then ch2 4 cycles, alternating. With req=4'b0001 alone, ch0 is held indefinitely.
- Aging, HOLD_MAX=0, AGE_MAX=8: req[3] constant; ch0 and ch1 issue overlapping 3-cycle bursts so a higher-priority request always exists at each arbitration -> ch3 granted at the first arbitration after age[3] reaches 8, within ≤12 cycles.
- Reset mid-operation: assert rst while ch2 is granted -> grant=0 next edge, table back to identity. Then req=4'b0100 -> grant=4'b0100 one cycle after rst deasserts.
